// File: rtl/seq_mult_pkg.sv
// Shared constants and helpers for the sequential shift-add / Booth multiplier.
// Holds the FSM state encodings, the Booth-pair encodings and the counter sizing function.
package seq_mult_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  typedef logic [1:0] booth_t;

  localparam booth_t BOOTH_NOP = 2'd0;
  localparam booth_t BOOTH_ADD = 2'd1;
  localparam booth_t BOOTH_SUB = 2'd2;

  // The counter must hold WIDTH itself, not just WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // {Q[0], q_m1}: 01 adds M, 10 subtracts M, 00 and 11 are runs with no action.
  function automatic booth_t booth_decode(input logic q0, input logic q_m1);
    booth_t op;
    op = BOOTH_NOP;
    if (q0 && !q_m1) begin
      op = BOOTH_SUB;
    end else if (!q0 && q_m1) begin
      op = BOOTH_ADD;
    end
    return op;
  endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One combinational multiplier iteration: conditional add (unsigned) or Booth add/sub
// (signed), followed by a one-bit right shift of {acc, Q, q_m1}.
module seq_mult_step
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q_m1,
  input  logic [WIDTH-1:0] i_m,
  input  logic             i_signed,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_m1
);

  logic [WIDTH:0] w_m_ext;
  logic [WIDTH:0] w_acc_in;
  logic [WIDTH:0] w_sum;
  logic           w_fill;

  always_comb begin
    w_m_ext  = i_signed ? {i_m[WIDTH-1], i_m} : {1'b0, i_m};
    // Unsigned mode keeps the extra acc bit clear so it can act as the adder carry.
    w_acc_in = i_signed ? i_acc : {1'b0, i_acc[WIDTH-1:0]};
    w_sum    = w_acc_in;
    if (!i_signed) begin
      if (i_q[0]) begin
        w_sum = w_acc_in + w_m_ext;
      end
    end else begin
      unique case (booth_decode(i_q[0], i_q_m1))
        BOOTH_ADD: w_sum = w_acc_in + w_m_ext;
        BOOTH_SUB: w_sum = w_acc_in - w_m_ext;
        default:   w_sum = w_acc_in;
      endcase
    end

    w_fill = i_signed ? w_sum[WIDTH] : 1'b0;
    o_acc  = {w_fill, w_sum[WIDTH:1]};
    o_q    = {w_sum[0], i_q[WIDTH-1:1]};
    o_q_m1 = i_signed ? i_q[0] : 1'b0;
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential WIDTH x WIDTH multiplier, one iteration per clock, with valid/ready on both
// sides. Unsigned uses shift-add, signed uses radix-2 Booth; full 2*WIDTH-bit product.
module seq_shift_add_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_t            r_state;
  logic [WIDTH:0]    r_acc;
  logic [WIDTH-1:0]  r_q;
  logic              r_q_m1;
  logic [WIDTH-1:0]  r_m;
  logic              r_signed;
  logic [CntW-1:0]   r_count;
  logic [2*WIDTH-1:0] r_p;

  logic [WIDTH:0]    w_acc_nxt;
  logic [WIDTH-1:0]  w_q_nxt;
  logic              w_q_m1_nxt;

  seq_mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc    (r_acc),
    .i_q      (r_q),
    .i_q_m1   (r_q_m1),
    .i_m      (r_m),
    .i_signed (r_signed),
    .o_acc    (w_acc_nxt),
    .o_q      (w_q_nxt),
    .o_q_m1   (w_q_m1_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_q      <= '0;
      r_q_m1   <= 1'b0;
      r_m      <= '0;
      r_signed <= 1'b0;
      r_count  <= '0;
      r_p      <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_m      <= a;
            r_q      <= b;
            r_signed <= is_signed;
            r_acc    <= '0;
            r_q_m1   <= 1'b0;
            r_count  <= CntW'(WIDTH);
            r_state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_acc   <= w_acc_nxt;
          r_q     <= w_q_nxt;
          r_q_m1  <= w_q_m1_nxt;
          r_count <= r_count - CntW'(1);
          // Last iteration: publish the product on the same edge that enters DONE.
          if (r_count == CntW'(1)) begin
            r_p     <= {w_acc_nxt[WIDTH-1:0], w_q_nxt};
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_BUSY) || (r_state == ST_DONE);
  assign p         = r_p;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: directed WIDTH=4 vectors and corner sequences, plus
// randomized WIDTH=8 operations against an arithmetic reference model.
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  logic reset;

  logic       v4_in_valid, v4_in_ready, s4, v4_out_valid, v4_out_ready, busy4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  logic       v8_in_valid, v8_in_ready, s8, v8_out_valid, v8_out_ready, busy8;
  logic [7:0] a8, b8;
  logic [15:0] p8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (v4_in_valid),
    .in_ready  (v4_in_ready),
    .a         (a4),
    .b         (b4),
    .is_signed (s4),
    .out_valid (v4_out_valid),
    .out_ready (v4_out_ready),
    .p         (p4),
    .busy      (busy4)
  );

  seq_shift_add_mult #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (v8_in_valid),
    .in_ready  (v8_in_ready),
    .a         (a8),
    .b         (b8),
    .is_signed (s8),
    .out_valid (v8_out_valid),
    .out_ready (v8_out_ready),
    .p         (p8),
    .busy      (busy8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sgn;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_mult8(input logic [7:0] a, input logic [7:0] b,
                                            input logic s);
    int pa, pb;
    pa = (s && a[7]) ? int'(a) - 256 : int'(a);
    pb = (s && b[7]) ? int'(b) - 256 : int'(b);
    return 16'(pa * pb);
  endfunction

  // Called at a negedge with the WIDTH=4 unit idle; out_ready held high.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     input logic [7:0] exp, input string name);
    int lat;
    a4 = a; b4 = b; s4 = s;
    v4_in_valid  = 1'b1;
    v4_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v4_in_valid = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
    lat = 0;
    while (!v4_out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, " latency"}, lat, 4);
    check({name, " p"}, p4, exp);
    @(posedge clk);
    @(negedge clk);
    check({name, " pulse"}, {v4_out_valid, v4_in_ready}, 2'b01);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] exp;
    int lat, idle, stall;
    exp  = ref_mult8(a, b, s);
    idle = $urandom_range(0, 3);
    v8_in_valid = 1'b0;
    repeat (idle) @(negedge clk);
    a8 = a; b8 = b; s8 = s;
    v8_in_valid  = 1'b1;
    v8_out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v8_in_valid = 1'b0;
    lat = 0;
    while (!v8_out_valid && lat < 100) begin
      a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
      v8_out_ready = 1'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    v8_out_ready = 1'b0;
    check("w8 latency", lat, 8);
    check("w8 product", p8, exp);
    stall = $urandom_range(0, 3);
    repeat (stall) begin
      v8_in_valid = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("w8 hold", {v8_out_valid, v8_in_ready, p8}, {2'b10, exp});
    end
    v8_in_valid  = 1'b0;
    v8_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v8_out_ready = 1'b0;
    check("w8 release", {v8_out_valid, v8_in_ready, busy8}, 3'b010);
  endtask

  initial begin
    logic seen_ov;
    logic [7:0] ra, rb;
    logic       rs;

    vecs[0] = '{a: 4'd8,  b: 4'd4,  sgn: 1'b0, exp: 8'h20};
    vecs[1] = '{a: 4'd15, b: 4'd15, sgn: 1'b0, exp: 8'hE1};
    vecs[2] = '{a: 4'd0,  b: 4'd13, sgn: 1'b0, exp: 8'h00};
    vecs[3] = '{a: 4'hD,  b: 4'd5,  sgn: 1'b1, exp: 8'hF1};
    vecs[4] = '{a: 4'h8,  b: 4'h8,  sgn: 1'b1, exp: 8'h40};
    vecs[5] = '{a: 4'd7,  b: 4'd7,  sgn: 1'b1, exp: 8'h31};
    vecs[6] = '{a: 4'hF,  b: 4'hF,  sgn: 1'b1, exp: 8'h01};
    vecs[7] = '{a: 4'h8,  b: 4'd7,  sgn: 1'b1, exp: 8'hC8};
    vecs[8] = '{a: 4'd3,  b: 4'd0,  sgn: 1'b1, exp: 8'h00};
    vecs[9] = '{a: 4'd13, b: 4'd11, sgn: 1'b0, exp: 8'h8F};

    reset = 1'b1;
    v4_in_valid = 1'b0; v4_out_ready = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0;
    v8_in_valid = 1'b0; v8_out_ready = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset w4 flags", {v4_in_ready, v4_out_valid, busy4}, 3'b100);
    check("reset w4 p", p4, 8'h00);
    check("reset w8 flags", {v8_in_ready, v8_out_valid, busy8}, 3'b100);
    check("reset w8 p", p8, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Backpressure: product and flags must hold while the consumer stalls.
    a4 = 4'd9; b4 = 4'd3; s4 = 1'b0;
    v4_in_valid = 1'b1; v4_out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v4_in_valid = 1'b0;
    for (int i = 0; i < 50 && !v4_out_valid; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("bp done", {v4_out_valid, p4}, {1'b1, 8'h1B});
    for (int i = 0; i < 5; i++) begin
      v4_in_valid = 1'b1;
      a4 = 4'($urandom); b4 = 4'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("bp hold", {v4_out_valid, v4_in_ready, busy4, p4}, {3'b101, 8'h1B});
    end
    v4_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v4_in_valid = 1'b0;
    check("bp release", {v4_out_valid, v4_in_ready, busy4, p4}, {3'b010, 8'h1B});

    // Reset in the second BUSY cycle discards the operation.
    a4 = 4'd5; b4 = 4'd5; s4 = 1'b0;
    v4_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v4_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst async flags", {v4_in_ready, v4_out_valid, busy4}, 3'b100);
    check("rst async p", p4, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("rst held", {v4_in_ready, v4_out_valid, busy4, p4}, {3'b100, 8'h00});
    reset = 1'b0;
    seen_ov = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      seen_ov |= v4_out_valid;
    end
    check("rst no out_valid", seen_ov, 1'b0);
    op4(4'd6, 4'd7, 1'b0, 8'h2A, "after reset");

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      if (i == 0) begin ra = 8'h80; rb = 8'h80; rs = 1'b1; end
      if (i == 1) begin ra = 8'hFF; rb = 8'hFF; rs = 1'b0; end
      if (i == 2) begin ra = 8'h00; rb = 8'h9C; rs = 1'b1; end
      if (i == 3) begin ra = 8'h7F; rb = 8'h80; rs = 1'b1; end
      op8(ra, rb, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
